// File: rtl/wb_pkg.sv
// Shared types and helpers for the write buffer between the cache and data memory.
// Optional read bypass is enabled by defining WB_READ_BYPASS_EN.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } wb_state_t;

    localparam int LINE_W_DEF = 128;
    localparam int LINE_OFS_W = $clog2(LINE_W_DEF / 8);
    localparam int ADDR_W_MAX = 64;

    // Line address: byte address with the offset-within-line bits shifted out.
    function automatic logic [ADDR_W_MAX-1:0] lineAddr(input logic [ADDR_W_MAX-1:0] addr,
                                                       input int ofsW);
        return addr >> ofsW;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Posted-write storage: circular buffer of {address, data} with head/tail/count.
// With WB_READ_BYPASS_EN defined it also reports, per entry, whether a valid
// buffered write falls in the same cache line as matchAddr.
module wb_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int OFS_W  = wb_pkg::LINE_OFS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] pushAddr,
    input  logic [DATA_W-1:0] pushData,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] headAddr,
    output logic [DATA_W-1:0] headData
`ifdef WB_READ_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] matchAddr,
    output logic [DEPTH-1:0]  matchVec
`endif
);
    import wb_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

    logic [ADDR_W-1:0] addrMem [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W:0]    count;
    logic              doPush;
    logic              doPop;

    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headAddr = addrMem[head];
    assign headData = dataMem[head];

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (doPush) tail <= tail + PTR_ONE;
            if (doPop)  head <= head + PTR_ONE;
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are meaningless outside the head..tail window, so no reset.
    always_ff @(posedge clk) begin
        if (doPush) begin
            addrMem[tail] <= pushAddr;
            dataMem[tail] <= pushData;
        end
    end

`ifdef WB_READ_BYPASS_EN
    logic [PTR_W-1:0] entryOfs [DEPTH];

    // Same-line hazard detect against every entry currently holding a pending write.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entryOfs[i] = PTR_W'(i) - head;
            matchVec[i] = ({1'b0, entryOfs[i]} < count) &&
                          (lineAddr(ADDR_W_MAX'(addrMem[i]), OFS_W) ==
                           lineAddr(ADDR_W_MAX'(matchAddr), OFS_W));
        end
    end
`endif

endmodule

// File: rtl/write_buffer.sv
// Posted-write buffer between the write-through cache and the single data-memory port.
// Stores are absorbed into wb_fifo and drained one at a time; line-fill reads share the port.
// Define WB_READ_BYPASS_EN to let a read miss overtake buffered writes to other lines.
//
// state | meaning
// IDLE  | no memory operation; arbitrates between draining a write and serving a read
// WRITE | head entry presented to memory until MemWriteReady, then popped
// READ  | line fill in flight until MemReadReady, then data captured and RdReady pulsed
module write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              WrReq,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    output logic              WrAck,
    input  logic              RdMiss,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic              RdReady,
    output logic [LINE_W-1:0] RdData,
    output logic              Full,
    output logic              Empty,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic              MemWrite,
    output logic              MemRdMiss,
    input  logic              MemWriteReady,
    input  logic              MemReadReady,
    input  logic [LINE_W-1:0] MemRdData
);
    import wb_pkg::*;

    localparam int OFS_W = $clog2(LINE_W / 8);

    wb_state_t         state;
    wb_state_t         nextState;
    logic              pop;
    logic              readBlocked;
    logic [ADDR_W-1:0] headAddr;
    logic [DATA_W-1:0] headData;
    logic [ADDR_W-1:0] lineBase;

    // Reset also masks acceptance so a store presented during reset is never acknowledged.
    assign WrAck    = WrReq && !Full && !Rst;
    assign lineBase = {RdAddr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

`ifdef WB_READ_BYPASS_EN
    logic [DEPTH-1:0] matchVec;
    assign readBlocked = |matchVec;
`else
    assign readBlocked = !Empty;
`endif

    wb_fifo #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .OFS_W (OFS_W)
    ) uFifo (
        .clk     (Clk),
        .rst     (Rst),
        .push    (WrAck),
        .pushAddr(WrAddr),
        .pushData(WrData),
        .pop     (pop),
        .full    (Full),
        .empty   (Empty),
        .headAddr(headAddr),
        .headData(headData)
`ifdef WB_READ_BYPASS_EN
        ,
        .matchAddr(RdAddr),
        .matchVec (matchVec)
`endif
    );

    // State register plus the registered read-return pulse and line data.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            RdReady <= 1'b0;
            RdData  <= '0;
        end else begin
            state   <= nextState;
            RdReady <= (state == READ) && MemReadReady;
            if ((state == READ) && MemReadReady) RdData <= MemRdData;
        end
    end

    // Next-state and memory-port muxing. RdReady high in IDLE means the cache has not yet
    // dropped the miss it just got data for, so that cycle must not start another read.
    always_comb begin
        nextState = state;
        MemWrite  = 1'b0;
        MemRdMiss = 1'b0;
        MemAddr   = '0;
        MemWData  = '0;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (RdMiss && !RdReady && !readBlocked) nextState = READ;
                else if (!Empty)                        nextState = WRITE;
            end
            WRITE: begin
                MemWrite = 1'b1;
                MemAddr  = headAddr;
                MemWData = headData;
                if (MemWriteReady) begin
                    pop       = 1'b1;
                    nextState = IDLE;
                end
            end
            READ: begin
                MemRdMiss = 1'b1;
                MemAddr   = lineBase;
                if (MemReadReady) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_write_buffer.sv
`timescale 1ns/1ps
module tb_write_buffer;
    import wb_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LINE_W = 128;
    localparam logic [127:0] LINE_A = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C;
    localparam logic [127:0] LINE_B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              WrReq;
    logic [ADDR_W-1:0] WrAddr;
    logic [DATA_W-1:0] WrData;
    logic              WrAck;
    logic              RdMiss;
    logic [ADDR_W-1:0] RdAddr;
    logic              RdReady;
    logic [LINE_W-1:0] RdData;
    logic              Full;
    logic              Empty;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic              MemWrite;
    logic              MemRdMiss;
    logic              MemWriteReady = 1'b0;
    logic              MemReadReady = 1'b0;
    logic [LINE_W-1:0] MemRdData;

    always #5 Clk = ~Clk;

    write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W)) dut (
        .Clk(Clk), .Rst(Rst), .WrReq(WrReq), .WrAddr(WrAddr), .WrData(WrData), .WrAck(WrAck),
        .RdMiss(RdMiss), .RdAddr(RdAddr), .RdReady(RdReady), .RdData(RdData),
        .Full(Full), .Empty(Empty), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemWrite(MemWrite), .MemRdMiss(MemRdMiss), .MemWriteReady(MemWriteReady),
        .MemReadReady(MemReadReady), .MemRdData(MemRdData)
    );

    // kind: 0 = write completed, 1 = read issued, 2 = RdReady seen
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t         evQ[$];
    int          wLat = 2;
    int          rLat = 2;
    int          wCnt = 0;
    int          rCnt = 0;
    logic [31:0] wAddr0;
    logic [31:0] wData0;
    bit          unstable = 1'b0;
    int          rdPulses = 0;
    int          nChecks = 0;
    int          nFail = 0;

    // Memory model: ready after wLat/rLat extra cycles of strobe, logs the traffic order.
    always @(negedge Clk) begin
        MemWriteReady = 1'b0;
        MemReadReady  = 1'b0;
        if (Rst) begin
            wCnt = 0;
            rCnt = 0;
        end else begin
            if (MemWrite) begin
                if (wCnt == 0) begin
                    wAddr0 = MemAddr;
                    wData0 = MemWData;
                end else if (MemAddr !== wAddr0 || MemWData !== wData0) begin
                    unstable = 1'b1;
                end
                if (wCnt == wLat) begin
                    MemWriteReady = 1'b1;
                    evQ.push_back('{2'd0, MemAddr, MemWData});
                    wCnt = 0;
                end else wCnt++;
            end else wCnt = 0;
            if (MemRdMiss) begin
                if (rCnt == 0) evQ.push_back('{2'd1, MemAddr, 32'd0});
                if (rCnt == rLat) begin
                    MemReadReady = 1'b1;
                    rCnt = 0;
                end else rCnt++;
            end else rCnt = 0;
            if (RdReady) begin
                rdPulses++;
                evQ.push_back('{2'd2, 32'd0, RdData[31:0]});
            end
        end
    end

    task automatic doStore(input logic [31:0] a, input logic [31:0] d);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        @(negedge Clk);
        WrReq = 1'b1; WrAddr = a; WrData = d;
        while (!ok && n < 300) begin
            #1;
            if (WrAck === 1'b1) ok = 1'b1;
            else begin
                @(negedge Clk);
                n++;
            end
        end
        nChecks++;
        if (!ok) begin nFail++; $display("FAIL store_ack addr=%h: WrAck never rose", a); end
        @(posedge Clk); #1;
        WrReq = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (n < 1000 && !(Empty === 1'b1 && dut.state == IDLE && MemWrite === 1'b0 && MemRdMiss === 1'b0)) begin
            @(negedge Clk);
            n++;
        end
        nChecks++;
        if (n >= 1000) begin nFail++; $display("FAIL %s drain: buffer not idle within bound, Empty=%b", tag, Empty); end
        repeat (2) @(negedge Clk);
    endtask

    task automatic waitRdReady(input string tag);
        int n;
        n = 0;
        while (n < 300 && RdReady !== 1'b1) begin
            @(negedge Clk);
            n++;
        end
        nChecks++;
        if (n >= 300) begin nFail++; $display("FAIL %s rdready: no RdReady within bound", tag); end
        RdMiss = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1; WrReq = 1'b1; WrAddr = 32'h1234; WrData = 32'h5678;
        repeat (2) @(negedge Clk);
        #1;
        nChecks++; if (WrAck !== 1'b0)     begin nFail++; $display("FAIL rst_wrack got=%b exp=0", WrAck); end
        nChecks++; if (Full !== 1'b0)      begin nFail++; $display("FAIL rst_full got=%b exp=0", Full); end
        nChecks++; if (Empty !== 1'b1)     begin nFail++; $display("FAIL rst_empty got=%b exp=1", Empty); end
        nChecks++; if (MemWrite !== 1'b0)  begin nFail++; $display("FAIL rst_memwrite got=%b exp=0", MemWrite); end
        nChecks++; if (MemRdMiss !== 1'b0) begin nFail++; $display("FAIL rst_memrdmiss got=%b exp=0", MemRdMiss); end
        nChecks++; if (RdReady !== 1'b0)   begin nFail++; $display("FAIL rst_rdready got=%b exp=0", RdReady); end
        nChecks++; if (RdData !== '0)      begin nFail++; $display("FAIL rst_rddata got=%h exp=0", RdData); end
        nChecks++; if (MemAddr !== '0)     begin nFail++; $display("FAIL rst_memaddr got=%h exp=0", MemAddr); end
        nChecks++; if (MemWData !== '0)    begin nFail++; $display("FAIL rst_memwdata got=%h exp=0", MemWData); end
        WrReq = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_latency();
        wLat = 2; evQ.delete();
        @(negedge Clk);
        WrReq = 1'b1; WrAddr = 32'h40; WrData = 32'h55;
        #1;
        nChecks++; if (WrAck !== 1'b1) begin nFail++; $display("FAIL lat_wrack got=%b exp=1", WrAck); end
        @(posedge Clk); #1;
        WrReq = 1'b0;
        nChecks++; if (dut.uFifo.count !== 3'd1) begin nFail++; $display("FAIL lat_count got=%0d exp=1", dut.uFifo.count); end
        nChecks++; if (MemWrite !== 1'b0) begin nFail++; $display("FAIL lat_memwrite_n1 got=%b exp=0", MemWrite); end
        @(posedge Clk); #1;
        nChecks++; if (MemWrite !== 1'b1) begin nFail++; $display("FAIL lat_memwrite_n2 got=%b exp=1", MemWrite); end
        nChecks++; if (MemAddr !== 32'h40) begin nFail++; $display("FAIL lat_memaddr got=%h exp=40", MemAddr); end
        nChecks++; if (MemWData !== 32'h55) begin nFail++; $display("FAIL lat_memwdata got=%h exp=55", MemWData); end
        waitIdle("lat");
        nChecks++; if (evQ.size() != 1) begin nFail++; $display("FAIL lat_nwrites got=%0d exp=1", evQ.size()); end
    endtask

    task automatic test_back_to_back();
        wLat = 2; evQ.delete(); unstable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            WrReq = 1'b1; WrAddr = 32'h100 + 32'(4 * k); WrData = 32'(k + 1);
            #1;
            nChecks++; if (WrAck !== 1'b1) begin nFail++; $display("FAIL b2b_wrack%0d got=%b exp=1", k, WrAck); end
        end
        @(negedge Clk);
        WrAddr = 32'h110; WrData = 32'd5;
        #1;
        nChecks++; if (Full !== 1'b1)  begin nFail++; $display("FAIL b2b_full got=%b exp=1", Full); end
        nChecks++; if (WrAck !== 1'b0) begin nFail++; $display("FAIL b2b_wrack_full got=%b exp=0", WrAck); end
        @(posedge Clk); #1;
        WrReq = 1'b0;
        waitIdle("b2b");
        nChecks++; if (evQ.size() != 4) begin nFail++; $display("FAIL b2b_nwrites got=%0d exp=4", evQ.size()); end
        for (int k = 0; k < 4 && k < evQ.size(); k++) begin
            nChecks++;
            if (evQ[k].kind !== 2'd0 || evQ[k].addr !== 32'h100 + 32'(4 * k) || evQ[k].data !== 32'(k + 1)) begin
                nFail++;
                $display("FAIL b2b_order%0d got kind=%0d addr=%h data=%h exp kind=0 addr=%h data=%h",
                         k, evQ[k].kind, evQ[k].addr, evQ[k].data, 32'h100 + 32'(4 * k), k + 1);
            end
        end
        nChecks++; if (unstable !== 1'b0) begin nFail++; $display("FAIL b2b_stable got=%b exp=0", unstable); end
    endtask

    task automatic test_wrap();
        wLat = 3; evQ.delete(); unstable = 1'b0;
        for (int k = 0; k < 10; k++) doStore(32'h500 + 32'(4 * k), 32'hC000 + 32'(k));
        waitIdle("wrap");
        nChecks++; if (evQ.size() != 10) begin nFail++; $display("FAIL wrap_nwrites got=%0d exp=10", evQ.size()); end
        for (int k = 0; k < 10 && k < evQ.size(); k++) begin
            nChecks++;
            if (evQ[k].addr !== 32'h500 + 32'(4 * k) || evQ[k].data !== 32'hC000 + 32'(k)) begin
                nFail++;
                $display("FAIL wrap_order%0d got addr=%h data=%h exp addr=%h data=%h",
                         k, evQ[k].addr, evQ[k].data, 32'h500 + 32'(4 * k), 32'hC000 + 32'(k));
            end
        end
        nChecks++; if (Empty !== 1'b1)    begin nFail++; $display("FAIL wrap_empty got=%b exp=1", Empty); end
        nChecks++; if (unstable !== 1'b0) begin nFail++; $display("FAIL wrap_stable got=%b exp=0", unstable); end
    endtask

    task automatic test_read_order();
        wLat = 2; rLat = 2; evQ.delete(); rdPulses = 0; MemRdData = LINE_A;
        doStore(32'h204, 32'h77);
        @(negedge Clk);
        RdMiss = 1'b1; RdAddr = 32'h200;
        waitRdReady("raw");
        nChecks++; if (RdData !== LINE_A) begin nFail++; $display("FAIL raw_rddata got=%h exp=%h", RdData, LINE_A); end
        repeat (5) @(negedge Clk);
        nChecks++; if (rdPulses != 1)     begin nFail++; $display("FAIL raw_pulses got=%0d exp=1", rdPulses); end
        nChecks++; if (RdData !== LINE_A) begin nFail++; $display("FAIL raw_hold got=%h exp=%h", RdData, LINE_A); end
        nChecks++;
        if (evQ.size() != 3) begin
            nFail++; $display("FAIL raw_nevents got=%0d exp=3", evQ.size());
        end else if (evQ[0].kind !== 2'd0 || evQ[0].addr !== 32'h204 || evQ[1].kind !== 2'd1 ||
                     evQ[1].addr !== 32'h200 || evQ[2].kind !== 2'd2) begin
            nFail++;
            $display("FAIL raw_order got kinds=%0d,%0d,%0d addrs=%h,%h exp kinds=0,1,2 addrs=204,200",
                     evQ[0].kind, evQ[1].kind, evQ[2].kind, evQ[0].addr, evQ[1].addr);
        end
    endtask

    task automatic test_read_latency();
        rLat = 2; evQ.delete(); rdPulses = 0; MemRdData = LINE_B;
        @(negedge Clk);
        RdMiss = 1'b1; RdAddr = 32'h2A4;
        #1;
        nChecks++; if (MemRdMiss !== 1'b0) begin nFail++; $display("FAIL rdlat_n0 got=%b exp=0", MemRdMiss); end
        @(posedge Clk); #1;
        nChecks++; if (MemRdMiss !== 1'b1) begin nFail++; $display("FAIL rdlat_n1 got=%b exp=1", MemRdMiss); end
        nChecks++; if (MemAddr !== 32'h2A0) begin nFail++; $display("FAIL rdlat_addr got=%h exp=2a0", MemAddr); end
        repeat (2) @(posedge Clk);
        #1;
        nChecks++; if (RdReady !== 1'b0) begin nFail++; $display("FAIL rdlat_early got=%b exp=0", RdReady); end
        @(posedge Clk); #1;
        nChecks++; if (RdReady !== 1'b1) begin nFail++; $display("FAIL rdlat_pulse got=%b exp=1", RdReady); end
        nChecks++; if (RdData !== LINE_B) begin nFail++; $display("FAIL rdlat_data got=%h exp=%h", RdData, LINE_B); end
        RdMiss = 1'b0;
        @(posedge Clk); #1;
        nChecks++; if (RdReady !== 1'b0) begin nFail++; $display("FAIL rdlat_once got=%b exp=0", RdReady); end
        waitIdle("rdlat");
        nChecks++; if (rdPulses != 1) begin nFail++; $display("FAIL rdlat_pulses got=%0d exp=1", rdPulses); end
    endtask

    task automatic test_bypass();
        wLat = 2; rLat = 2; evQ.delete(); rdPulses = 0; MemRdData = LINE_A;
        doStore(32'h300, 32'h33);
        @(negedge Clk);
        RdMiss = 1'b1; RdAddr = 32'h400;
        waitRdReady("byp");
        waitIdle("byp");
        nChecks++;
        if (evQ.size() != 3) begin
            nFail++; $display("FAIL byp_nevents got=%0d exp=3", evQ.size());
`ifdef WB_READ_BYPASS_EN
        end else if (evQ[0].kind !== 2'd1 || evQ[0].addr !== 32'h400 || evQ[1].kind !== 2'd2 ||
                     evQ[2].kind !== 2'd0 || evQ[2].addr !== 32'h300) begin
            nFail++;
            $display("FAIL byp_order got kinds=%0d,%0d,%0d exp kinds=1,2,0", evQ[0].kind, evQ[1].kind, evQ[2].kind);
`else
        end else if (evQ[0].kind !== 2'd0 || evQ[0].addr !== 32'h300 || evQ[1].kind !== 2'd1 ||
                     evQ[1].addr !== 32'h400 || evQ[2].kind !== 2'd2) begin
            nFail++;
            $display("FAIL byp_order got kinds=%0d,%0d,%0d exp kinds=0,1,2", evQ[0].kind, evQ[1].kind, evQ[2].kind);
`endif
        end
    endtask

    task automatic test_reset_mid_write();
        wLat = 1000; evQ.delete();
        doStore(32'h600, 32'h60);
        doStore(32'h604, 32'h61);
        doStore(32'h608, 32'h62);
        repeat (3) @(negedge Clk);
        #1;
        nChecks++; if (MemWrite !== 1'b1) begin nFail++; $display("FAIL rstw_busy got=%b exp=1", MemWrite); end
        nChecks++; if (dut.uFifo.count !== 3'd3) begin nFail++; $display("FAIL rstw_count3 got=%0d exp=3", dut.uFifo.count); end
        #2;
        Rst = 1'b1;
        @(negedge Clk); #1;
        nChecks++; if (Empty !== 1'b1)    begin nFail++; $display("FAIL rstw_empty got=%b exp=1", Empty); end
        nChecks++; if (MemWrite !== 1'b0) begin nFail++; $display("FAIL rstw_memwrite got=%b exp=0", MemWrite); end
        nChecks++; if (dut.uFifo.count !== 3'd0) begin nFail++; $display("FAIL rstw_count got=%0d exp=0", dut.uFifo.count); end
        @(negedge Clk);
        Rst = 1'b0; wLat = 2; evQ.delete();
        doStore(32'h10, 32'hAA);
        waitIdle("rstw");
        nChecks++;
        if (evQ.size() != 1) begin
            nFail++; $display("FAIL rstw_nwrites got=%0d exp=1", evQ.size());
        end else if (evQ[0].addr !== 32'h10 || evQ[0].data !== 32'hAA) begin
            nFail++; $display("FAIL rstw_write got addr=%h data=%h exp addr=10 data=aa", evQ[0].addr, evQ[0].data);
        end
    endtask

    // Runs right after test_reset_mid_write: one store since reset, so head=tail=1 here.
    task automatic test_simul();
        wLat = 2; evQ.delete();
        doStore(32'h700, 32'h70);
        doStore(32'h704, 32'h71);
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        WrReq = 1'b1; WrAddr = 32'h708; WrData = 32'h72;
        #1;
        nChecks++; if (dut.uFifo.count !== 3'd2) begin nFail++; $display("FAIL sim_count_pre got=%0d exp=2", dut.uFifo.count); end
        nChecks++; if (MemWriteReady !== 1'b1) begin nFail++; $display("FAIL sim_pop_cycle got=%b exp=1", MemWriteReady); end
        nChecks++; if (WrAck !== 1'b1) begin nFail++; $display("FAIL sim_wrack got=%b exp=1", WrAck); end
        nChecks++; if (dut.uFifo.head !== 2'd1 || dut.uFifo.tail !== 2'd3) begin
            nFail++; $display("FAIL sim_ptr_pre got head=%0d tail=%0d exp head=1 tail=3", dut.uFifo.head, dut.uFifo.tail);
        end
        @(posedge Clk); #1;
        WrReq = 1'b0;
        nChecks++; if (dut.uFifo.count !== 3'd2) begin nFail++; $display("FAIL sim_count got=%0d exp=2", dut.uFifo.count); end
        nChecks++; if (dut.uFifo.head !== 2'd2 || dut.uFifo.tail !== 2'd0) begin
            nFail++; $display("FAIL sim_ptr got head=%0d tail=%0d exp head=2 tail=0", dut.uFifo.head, dut.uFifo.tail);
        end
        waitIdle("sim");
        nChecks++;
        if (evQ.size() != 3) begin
            nFail++; $display("FAIL sim_nwrites got=%0d exp=3", evQ.size());
        end else if (evQ[0].addr !== 32'h700 || evQ[1].addr !== 32'h704 || evQ[2].addr !== 32'h708 ||
                     evQ[2].data !== 32'h72) begin
            nFail++;
            $display("FAIL sim_order got %h,%h,%h exp 700,704,708", evQ[0].addr, evQ[1].addr, evQ[2].addr);
        end
    endtask

    initial begin
        Rst = 1'b1; WrReq = 1'b0; WrAddr = '0; WrData = '0;
        RdMiss = 1'b0; RdAddr = '0; MemRdData = LINE_A;
        test_reset();
        test_latency();
        test_back_to_back();
        test_wrap();
        test_read_order();
        test_read_latency();
        test_bypass();
        test_reset_mid_write();
        test_simul();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/write_buffer.md
Name: write_buffer

Overview:
- Posted-write FIFO between the write-through data cache (ezcache) and the backing data memory.
- Absorbs write-through stores so that a store no longer stalls the pipeline for the full memory write latency.
- Serialises buffered writes and cache line-fill read misses onto the single data-memory port.
- Guarantees read-after-write ordering: a read miss never returns stale memory data.

Parameters:
- DEPTH, 4: number of buffered writes. Must be a power of 2, ≥2.
- ADDR_W, 32: byte address width.
- DATA_W, 32: store word width.
- LINE_W, 128: cache line width returned on a read miss.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous reset, active-high.
- WrReq  in  1  cache requests a write-through store this cycle.
- WrAddr  in  ADDR_W  store byte address.
- WrData  in  DATA_W  store data.
- WrAck  out  1  store accepted this cycle; feeds hazard WriteReady.
- RdMiss  in  1  cache line-fill request; held high until RdReady.
- RdAddr  in  ADDR_W  miss byte address.
- RdReady  out  1  one-cycle pulse; RdData valid.
- RdData  out  LINE_W  returned line.
- Full  out  1  count==DEPTH.
- Empty  out  1  count==0.
- MemAddr  out  ADDR_W  address to data memory.
- MemWData  out  DATA_W  write data to data memory.
- MemWrite  out  1  write strobe (MemWriteThrough).
- MemRdMiss  out  1  read strobe (ReadMiss).
- MemWriteReady  in  1  memory finished current write.
- MemReadReady  in  1  memory finished read; MemRdData valid.
- MemRdData  in  LINE_W  memory line data.

Behaviour:
- Reset, asynchronous, Rst high:
  - count, head and tail pointers return to 0; state returns to IDLE.
  - Buffered entries are discarded; a request in flight at reset is abandoned.
  - MemWrite=0, MemRdMiss=0, RdReady=0, RdData=0, MemAddr=0, MemWData=0, WrAck=0, Full=0, Empty=1.
- Enqueue:
  - WrAck = WrReq && !Full (combinational).
  - On WrAck the entry {WrAddr, WrData} is written at tail, tail increments mod DEPTH, and count increments.
  - No acceptance while Full, even if a pop occurs in the same cycle.
- FSM, states IDLE, WRITE, READ, all registered.
- IDLE:
  - If count>0 and no read may bypass: go to WRITE.
  - Else if RdMiss: go to READ.
  - Else stay in IDLE.
  - All memory strobes are low in IDLE.
- WRITE:
  - MemWrite=1; MemAddr and MemWData are taken from the head entry and held stable.
  - On MemWriteReady: pop (head++, count--) and go to IDLE.
  - One IDLE cycle separates consecutive memory operations.
- READ:
  - MemRdMiss=1; MemAddr = RdAddr with the low log2(LINE_W/8) bits zeroed.
  - On MemReadReady: capture MemRdData into RdData, pulse RdReady for 1 cycle, go to IDLE.
- Latency:
  - Store acked in cycle N: count=1 at N+1, MemWrite high from N+2.
  - Read with buffer empty, RdMiss first high at N: MemRdMiss high from N+1; RdReady high the cycle after MemReadReady.
- Simultaneous enqueue and pop: count is unchanged and both pointers advance.
- Pointer wrap-around: modulo DEPTH.
- Ordering, default: a read waits until count==0 and the FSM returns to IDLE.
- RdData holds its last value between pulses.

Optional Feature:
- Macro: WB_READ_BYPASS_EN.
- Defined:
  - In IDLE, RdMiss has priority over pending writes when no valid entry's address matches RdAddr at line granularity (addr bits above the line offset).
  - On any match, the FSM drains writes first and re-checks in IDLE after every pop.
- Undefined: reads always wait for the buffer to drain. The comparators are not built.

Decomposition:
- Package wb_pkg holds:
  - wb_state_t enum {IDLE, WRITE, READ};
  - LINE_OFS_W = log2(LINE_W/8);
  - a line-address extraction function.
- One sub-module, wb_fifo: storage array, head/tail/count, push/pop, Full/Empty, head outputs, and (under the macro) a per-entry valid-address match vector.
- The FSM and memory muxing stay in write_buffer.

Test Plan:
- Reset mid-WRITE with 3 entries buffered → next cycle Empty=1, MemWrite=0, count=0. Subsequent store 0x10/0xAA drains alone.
- Back-to-back stores 0x100..0x10C (data 1..4), memory 2-cycle ready:
  - WrAck high on all 4; Full=1 after the 4th; 5th WrReq gets WrAck=0.
  - Memory sees the 4 writes in order, each with MemAddr and MemWData stable until MemWriteReady.
- Wrap-around: 10 stores with drain rate 1/3 of issue rate → no loss, order preserved, Empty=1 at end.
- Read miss 0x200 with a store to 0x204 buffered, macro off or on (same line): write completes before MemRdMiss rises. RdReady pulses exactly once with MemRdData (0xDEAD_BEEF_…).
- Macro on, store to 0x300 buffered, read miss 0x400 (different line): MemRdMiss issued before MemWrite; RdReady precedes the write drain.
- Simultaneous WrReq and MemWriteReady at count=2 → count stays 2, head and tail both advance.
